// File: rtl/dtop_pkg.sv
// Shared widths, state type and MISR step for the dtop response checker.
package dtop_pkg;

  localparam int unsigned SC_W    = 37;
  localparam int unsigned CNTRL_W = 8;

  // x^37 + x^5 + x^4 + x^3 + x^2 + x + 1
  localparam logic [SC_W-1:0] MISR_POLY = 37'h3F;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Galois-form MISR step: shift, fold the MSB back through the taps, mix in data.
  function automatic logic [SC_W-1:0] misr_next(input logic [SC_W-1:0] sig,
                                                input logic [SC_W-1:0] din);
    return {sig[SC_W-2:0], 1'b0} ^ (sig[SC_W-1] ? MISR_POLY : '0) ^ din;
  endfunction

endpackage

// File: rtl/dtop_misr.sv
// Galois-form multiple-input signature register with synchronous seed load.
module dtop_misr
  import dtop_pkg::*;
#(
  parameter int unsigned W    = dtop_pkg::SC_W,
  parameter logic [W-1:0] POLY = W'(dtop_pkg::MISR_POLY),
  parameter logic [W-1:0] SEED = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] sig_out
);

  logic [W-1:0] sig_d, sig_q;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (enable) begin
      sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= SEED;
    else        sig_q <= sig_d;
  end

  assign sig_out = sig_q;

endmodule

// File: rtl/dtop_resp_checker.sv
// dtop response checker: MISR compaction, code-order check, pass/fail verdict.
// Optional macro DTOP_RESP_FIRST_ERR_EN adds err_code/err_vld first-fault capture.
module dtop_resp_checker
  import dtop_pkg::*;
#(
  parameter int unsigned             SC_W       = dtop_pkg::SC_W,
  parameter int unsigned             CNTRL_W    = dtop_pkg::CNTRL_W,
  parameter logic [CNTRL_W-1:0]      LAST_CODE  = CNTRL_W'(63),
  parameter logic [SC_W-1:0]         SEED       = '0,
  parameter logic [SC_W-1:0]         GOLDEN_SIG = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sample_vld,
  input  logic [CNTRL_W-1:0] cntrl,
  input  logic [SC_W-1:0]    scout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               seq_err,
  output logic [SC_W-1:0]    signature,
`ifdef DTOP_RESP_FIRST_ERR_EN
  output logic [CNTRL_W-1:0] err_code,
  output logic               err_vld,
`endif
  output logic [CNTRL_W-1:0] sample_cnt
);

  state_e             state_d, state_q;
  logic [CNTRL_W-1:0] cnt_d, cnt_q;
  logic [CNTRL_W-1:0] exp_d, exp_q;
  logic               seq_err_d, seq_err_q;
  logic               pass_d, pass_q;
  logic               accept;
  logic               code_bad;

  // start wins over a coincident sample, so that sample is never accepted
  assign accept   = (state_q == CAPTURE) && sample_vld && !start;
  assign code_bad = (cntrl != exp_q);

  dtop_misr #(
    .W    (SC_W),
    .POLY (SC_W'(MISR_POLY)),
    .SEED (SEED)
  ) u_misr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (start),
    .enable  (accept),
    .data_in (scout),
    .sig_out (signature)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    seq_err_d = seq_err_q;
    pass_d    = pass_q;
    if (start) begin
      state_d   = CAPTURE;
      cnt_d     = '0;
      exp_d     = '0;
      seq_err_d = 1'b0;
      pass_d    = 1'b0;
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
      exp_d = cntrl + 1'b1;
      if (code_bad) seq_err_d = 1'b1;
      // verdict folds in the final sample's own compaction and order check
      if (cntrl == LAST_CODE) begin
        state_d = DONE;
        pass_d  = (misr_next(signature, scout) == GOLDEN_SIG) && !seq_err_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      exp_q     <= '0;
      seq_err_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      seq_err_q <= seq_err_d;
      pass_q    <= pass_d;
    end
  end

`ifdef DTOP_RESP_FIRST_ERR_EN
  logic [CNTRL_W-1:0] err_code_d, err_code_q;
  logic               err_vld_d, err_vld_q;

  always_comb begin
    err_code_d = err_code_q;
    err_vld_d  = err_vld_q;
    if (start) begin
      err_code_d = '0;
      err_vld_d  = 1'b0;
    end else if (accept && code_bad && !seq_err_q) begin
      err_code_d = cntrl;
      err_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_code_q <= '0;
      err_vld_q  <= 1'b0;
    end else begin
      err_code_q <= err_code_d;
      err_vld_q  <= err_vld_d;
    end
  end

  assign err_code = err_code_q;
  assign err_vld  = err_vld_q;
`endif

  assign busy       = (state_q == CAPTURE);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign seq_err    = seq_err_q;
  assign sample_cnt = cnt_q;

endmodule
